// File: rtl/reverb_template_s2m_fifo_reader_if.sv
// Stream-sink and MM-read-slave bundle for the s2m FIFO reader.
// The master side drives the stream word and the read request; the slave side answers.
interface reverb_template_s2m_fifo_reader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] avalonst_sink_data;
  logic              avalonst_sink_valid;
  logic              avalonst_sink_ready;
  logic              avalonmm_read_slave_address;
  logic              avalonmm_read_slave_read;
  logic              avalonmm_read_slave_waitrequest;
  logic [DATA_W-1:0] avalonmm_read_slave_readdata;
  logic              avalonmm_read_slave_readdatavalid;

  modport master (
    output avalonst_sink_data,
    output avalonst_sink_valid,
    input  avalonst_sink_ready,
    output avalonmm_read_slave_address,
    output avalonmm_read_slave_read,
    input  avalonmm_read_slave_waitrequest,
    input  avalonmm_read_slave_readdata,
    input  avalonmm_read_slave_readdatavalid
  );

  modport slave (
    input  avalonst_sink_data,
    input  avalonst_sink_valid,
    output avalonst_sink_ready,
    input  avalonmm_read_slave_address,
    input  avalonmm_read_slave_read,
    output avalonmm_read_slave_waitrequest,
    output avalonmm_read_slave_readdata,
    output avalonmm_read_slave_readdatavalid
  );
endinterface

// File: rtl/reverb_template_s2m_fifo_reader.sv
// Stream-to-MM FIFO: buffers ST words in a register FIFO; CPU pops (addr 0) or reads status (addr 1)
// with fixed 1-cycle read latency. Sink stalls when full; pops stall via waitrequest when empty.
module reverb_template_s2m_fifo_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                          clock,
  input  logic                          reset_n,
  reverb_template_s2m_fifo_reader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readdatavalid_q, readdatavalid_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              accept;
  logic              stat_rd;
  logic [DATA_W-1:0] status_word;

  // Handshake outputs depend only on registered count, never on same-cycle traffic.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  assign bus.avalonst_sink_ready             = reset_n & ~full;
  assign bus.avalonmm_read_slave_waitrequest = ~reset_n | (~bus.avalonmm_read_slave_address & empty);
  assign bus.avalonmm_read_slave_readdata      = readdata_q;
  assign bus.avalonmm_read_slave_readdatavalid = readdatavalid_q;

  assign push    = bus.avalonst_sink_valid & bus.avalonst_sink_ready;
  assign accept  = bus.avalonmm_read_slave_read & ~bus.avalonmm_read_slave_waitrequest;
  assign pop     = accept & ~bus.avalonmm_read_slave_address;
  assign stat_rd = accept & bus.avalonmm_read_slave_address;

  always_comb begin
    status_word                = '0;
    status_word[0]             = empty;
    status_word[1]             = full;
    status_word[8 +: CNT_W]    = count_q;

    wr_ptr_d        = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d        = rd_ptr_q + ADDR_W'(pop);
    count_d         = count_q;
    readdata_d      = readdata_q;
    readdatavalid_d = accept;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Status reflects the count before this cycle's push/pop.
    if (pop) begin
      readdata_d = mem_q[rd_ptr_q];
    end else if (stat_rd) begin
      readdata_d = status_word;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  // Storage needs no reset; only words behind a valid count are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.avalonst_sink_data;
    end
  end
endmodule

// File: tb/tb_reverb_template_s2m_fifo_reader.sv
// Bench for the s2m FIFO reader: directed scenarios plus random traffic against a queue model.
module tb_reverb_template_s2m_fifo_reader;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reverb_template_s2m_fifo_reader_if #(.DATA_W(32)) bus ();

  reverb_template_s2m_fifo_reader #(.DATA_W(32), .ADDR_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_q [$];
  logic        exp_rdv   = 1'b0;
  logic [31:0] exp_rd    = 32'h0;
  bit          last_push = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_of(input int n);
    return 32'(n * 256 + ((n == 64) ? 2 : 0) + ((n == 0) ? 1 : 0));
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit          er, ew, acc, addr, vld;
    logic [31:0] din;
    @(negedge clock);
    if (!reset_n) begin
      model_q.delete();
      exp_rdv = 1'b0;
      exp_rd  = 32'h0;
    end
    addr = bus.avalonmm_read_slave_address;
    vld  = bus.avalonst_sink_valid;
    din  = bus.avalonst_sink_data;
    er   = reset_n && (model_q.size() != 64);
    ew   = !reset_n || (!addr && model_q.size() == 0);
    chk("ready",    32'(bus.avalonst_sink_ready),               32'(er));
    chk("waitreq",  32'(bus.avalonmm_read_slave_waitrequest),   32'(ew));
    chk("rdvalid",  32'(bus.avalonmm_read_slave_readdatavalid), 32'(exp_rdv));
    chk("readdata", bus.avalonmm_read_slave_readdata,           exp_rd);
    last_push = vld && er;
    acc       = bus.avalonmm_read_slave_read && !ew;
    @(posedge clock);
    exp_rdv = acc;
    if (acc) begin
      if (!addr) exp_rd = model_q.pop_front();
      else       exp_rd = status_of(model_q.size());
    end
    if (last_push) model_q.push_back(din);
    #1;
  endtask

  task automatic idle_inputs();
    bus.avalonst_sink_valid         = 1'b0;
    bus.avalonst_sink_data          = 32'h0;
    bus.avalonmm_read_slave_read    = 1'b0;
    bus.avalonmm_read_slave_address = 1'b0;
  endtask

  task automatic status_check(input string tag, input logic [31:0] exp);
    bus.avalonmm_read_slave_address = 1'b1;
    bus.avalonmm_read_slave_read    = 1'b1;
    cycle();
    bus.avalonmm_read_slave_read    = 1'b0;
    bus.avalonmm_read_slave_address = 1'b0;
    chk(tag, bus.avalonmm_read_slave_readdata, exp);
    cycle();
  endtask

  task automatic fill(input int n);
    bus.avalonst_sink_valid = 1'b1;
    for (int c = 0; c < 200 && model_q.size() < n; c++) begin
      bus.avalonst_sink_data = $urandom;
      cycle();
    end
    bus.avalonst_sink_valid = 1'b0;
  endtask

  task automatic drain();
    bus.avalonmm_read_slave_address = 1'b0;
    bus.avalonmm_read_slave_read    = 1'b1;
    for (int c = 0; c < 200 && model_q.size() > 0; c++) cycle();
    bus.avalonmm_read_slave_read = 1'b0;
    cycle();
  endtask

  initial begin
    int nxt;
    idle_inputs();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    status_check("reset_status", 32'h0000_0001);

    // Fill with an incrementing pattern; a 65th word must be held off.
    nxt = 0;
    bus.avalonst_sink_valid = 1'b1;
    for (int c = 0; c < 80 && nxt < 64; c++) begin
      bus.avalonst_sink_data = 32'(nxt);
      cycle();
      if (last_push) nxt++;
    end
    bus.avalonst_sink_data = 32'h40;
    repeat (3) cycle();
    chk("full_ready", 32'(bus.avalonst_sink_ready), 32'h0);
    bus.avalonst_sink_valid = 1'b0;
    status_check("full_status", 32'h0000_4002);

    drain();
    chk("empty_waitreq", 32'(bus.avalonmm_read_slave_waitrequest), 32'h1);
    status_check("empty_status", 32'h0000_0001);

    // Steady state at count 10 with wrap-around.
    fill(10);
    bus.avalonst_sink_valid         = 1'b1;
    bus.avalonmm_read_slave_read    = 1'b1;
    bus.avalonmm_read_slave_address = 1'b0;
    repeat (20) begin
      bus.avalonst_sink_data = $urandom;
      cycle();
    end
    idle_inputs();
    cycle();
    status_check("steady_status", 32'h0000_0A00);
    drain();

    // No fall-through: word pushed into empty FIFO pops one cycle later.
    bus.avalonmm_read_slave_read = 1'b1;
    bus.avalonst_sink_valid      = 1'b1;
    bus.avalonst_sink_data       = 32'hDEAD_BEEF;
    cycle();
    bus.avalonst_sink_valid = 1'b0;
    cycle();
    bus.avalonmm_read_slave_read = 1'b0;
    chk("ft_data",  bus.avalonmm_read_slave_readdata, 32'hDEAD_BEEF);
    chk("ft_valid", 32'(bus.avalonmm_read_slave_readdatavalid), 32'h1);
    cycle();

    // Full with simultaneous pop and pending push.
    fill(64);
    bus.avalonmm_read_slave_read = 1'b1;
    bus.avalonst_sink_valid      = 1'b1;
    bus.avalonst_sink_data       = 32'h0000_55AA;
    cycle();
    bus.avalonmm_read_slave_read = 1'b0;
    chk("free_ready", 32'(bus.avalonst_sink_ready), 32'h1);
    cycle();
    bus.avalonst_sink_valid = 1'b0;
    status_check("refull_status", 32'h0000_4002);
    drain();

    // Reset mid-operation with a read in flight.
    fill(30);
    bus.avalonmm_read_slave_read = 1'b1;
    cycle();
    bus.avalonmm_read_slave_read = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_rdvalid", 32'(bus.avalonmm_read_slave_readdatavalid), 32'h0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("rst_ready", 32'(bus.avalonst_sink_ready), 32'h1);
    status_check("rst_status", 32'h0000_0001);

    // Random traffic with varying push/pop pressure.
    for (int blk = 0; blk < 12; blk++) begin
      int pv, pr;
      pv = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        bus.avalonst_sink_valid         = ($urandom_range(0, 99) < pv);
        bus.avalonst_sink_data          = $urandom;
        bus.avalonmm_read_slave_read    = ($urandom_range(0, 99) < pr);
        bus.avalonmm_read_slave_address = ($urandom_range(0, 7) == 0);
        if (blk == 6 && c == 100) reset_n = 1'b0;
        if (blk == 6 && c == 102) reset_n = 1'b1;
        cycle();
      end
    end
    idle_inputs();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
